// File: rtl/tone_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tone_mixer
//  Description : NCH independent square-wave tone generators, each with an
//                optional note length in milliseconds, mixed into a single
//                PWM audio bit. The mixer sums the active channel outputs and
//                compares that sum against a free-running 0..NCH-1 counter, so
//                the PWM density is (active channels)/NCH.
//  Ports       : clock100  - 100 MHz clock (single clock domain)
//                reset     - synchronous, active-high
//                period    - per-channel period in clock100 cycles, [i*PW +: PW]
//                duration  - per-channel note length in ms, 0 = until stopped
//                start     - per-channel one-cycle note request
//                stop      - per-channel one-cycle stop request (beats start)
//                duty      - per-channel duty in 1/256 units, [i*8 +: 8]
//                            (present only with TONE_MIXER_DUTY_EN defined)
//                busy      - channel is playing
//                done      - one-cycle pulse when a timed note expires
//                audPWM    - mixed PWM audio output
//                audEn     - amplifier enable (any channel busy)
//  Options     : `define TONE_MIXER_DUTY_EN to add the duty input; otherwise
//                the high time is fixed at period>>1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_mixer #(
   parameter int NCH          = 4,
   parameter int PW           = 32,
   parameter int DW           = 16,
   parameter int TICKS_PER_MS = 100000
) (
   input  logic              clock100,
   input  logic              reset,
   input  logic [NCH*PW-1:0] period,
   input  logic [NCH*DW-1:0] duration,
   input  logic [NCH-1:0]    start,
   input  logic [NCH-1:0]    stop,
`ifdef TONE_MIXER_DUTY_EN
   input  logic [NCH*8-1:0]  duty,
`endif
   output logic [NCH-1:0]    busy,
   output logic [NCH-1:0]    done,
   output logic              audPWM,
   output logic              audEn
);

   localparam int c_TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam int c_MW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int c_SW = $clog2(NCH + 1);
   localparam int c_CW = 8;
   localparam logic [c_TW-1:0] c_TLAST = c_TW'(TICKS_PER_MS - 1);
   localparam logic [c_MW-1:0] c_MLAST = c_MW'(NCH - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PLAY = 1'b1
   } state_t;

   wire  [NCH-1:0]  w_sq;
   logic [c_SW-1:0] w_sum;
   logic [c_SW-1:0] r_sum;
   logic [c_MW-1:0] r_mix_cnt;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t          r_state;
      logic [PW-1:0]   r_per;
      logic [PW-1:0]   r_thr;
      logic [PW-1:0]   r_cnt;
      logic [DW-1:0]   r_dur;
      logic [DW-1:0]   r_ms;
      logic [c_TW-1:0] r_pre;
      logic            r_done;
      logic [PW-1:0]   w_per;
      logic [DW-1:0]   w_dur;
      logic [PW-1:0]   w_thr;
      logic            w_start_ok;

      assign w_per      = period[i*PW +: PW];
      assign w_dur      = duration[i*DW +: DW];
      assign w_start_ok = start[i] && (w_per >= PW'(2));

      // The high-time threshold is fixed at start so the per-cycle compare
      // needs no arithmetic on the live inputs.
`ifdef TONE_MIXER_DUTY_EN
      assign w_thr = PW'(({8'd0, w_per} * {{PW{1'b0}}, duty[i*8 +: 8]}) >> 8);
`else
      assign w_thr = w_per >> 1;
`endif

      always_ff @(posedge clock100) begin
         if (reset) begin
            r_state <= S_IDLE;
            r_per   <= '0;
            r_thr   <= '0;
            r_dur   <= '0;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_ms    <= '0;
            r_done  <= 1'b0;
         end else begin
            r_done <= 1'b0;
            if (stop[i]) begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_pre   <= '0;
               r_ms    <= '0;
            end else if (w_start_ok) begin
               // Same path for a fresh start and a restart while playing.
               r_state <= S_PLAY;
               r_per   <= w_per;
               r_thr   <= w_thr;
               r_dur   <= w_dur;
               r_cnt   <= '0;
               r_pre   <= '0;
               r_ms    <= '0;
            end else if (r_state == S_PLAY) begin
               if (r_cnt == r_per - 1'b1) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
               if (r_dur != '0) begin
                  if (r_pre == c_TLAST) begin
                     r_pre <= '0;
                     // Last tick of the last ms: leave PLAY and pulse done
                     // in the same cycle busy drops.
                     if (r_ms == r_dur - 1'b1) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_ms    <= '0;
                     end else begin
                        r_ms <= r_ms + 1'b1;
                     end
                  end else begin
                     r_pre <= r_pre + 1'b1;
                  end
               end
            end
         end
      end

      assign busy[i] = (r_state == S_PLAY);
      assign done[i] = r_done;
      assign w_sq[i] = (r_state == S_PLAY) && (r_cnt < r_thr);
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < NCH; k++) begin
         w_sum = w_sum + c_SW'(w_sq[k]);
      end
   end

   always_ff @(posedge clock100) begin
      if (reset) begin
         r_sum     <= '0;
         r_mix_cnt <= '0;
         audPWM    <= 1'b0;
         audEn     <= 1'b0;
      end else begin
         r_sum     <= w_sum;
         r_mix_cnt <= (r_mix_cnt == c_MLAST) ? '0 : r_mix_cnt + 1'b1;
         audPWM    <= (c_CW'(r_mix_cnt) < c_CW'(r_sum));
         audEn     <= |busy;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tone_mixer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tone_mixer
//  Description : Directed scoreboard bench for tone_mixer (NCH=4,
//                TICKS_PER_MS=10). Each scenario writes the expected channel
//                timeline (busy/done/square per edge), derives mixer outputs
//                from it, and queues per-edge expectations that are popped
//                as the clock advances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_mixer;
   localparam int NCH = 4;
   localparam int PW  = 32;
   localparam int DW  = 16;
   localparam int TPM = 10;

   logic              clock100 = 1'b0;
   logic              reset    = 1'b1;
   logic [NCH*PW-1:0] period   = '0;
   logic [NCH*DW-1:0] duration = '0;
   logic [NCH-1:0]    start    = '0;
   logic [NCH-1:0]    stop     = '0;
`ifdef TONE_MIXER_DUTY_EN
   logic [NCH*8-1:0]  duty     = {NCH{8'd128}};
`endif
   wire  [NCH-1:0]    busy;
   wire  [NCH-1:0]    done;
   wire               audPWM;
   wire               audEn;

   always #5 clock100 = ~clock100;

   tone_mixer #(.NCH(NCH), .PW(PW), .DW(DW), .TICKS_PER_MS(TPM)) dut (
      .clock100 (clock100),
      .reset    (reset),
      .period   (period),
      .duration (duration),
      .start    (start),
      .stop     (stop),
`ifdef TONE_MIXER_DUTY_EN
      .duty     (duty),
`endif
      .busy     (busy),
      .done     (done),
      .audPWM   (audPWM),
      .audEn    (audEn)
   );

   typedef struct {
      int             at;
      string          tag;
      logic [NCH-1:0] busy;
      logic [NCH-1:0] done;
      logic           en;
      logic           pwm;
   } exp_t;

   exp_t           sb[$];
   bit [NCH-1:0]   a_busy[int];
   bit [NCH-1:0]   a_done[int];
   int             a_sq[int];
   int             edge_n   = 0;
   int             rst_edge = 0;
   int             checks   = 0;
   int             failures = 0;
   int             s;

   function automatic bit [NCH-1:0] busy_at(int e);
      return a_busy.exists(e) ? a_busy[e] : '0;
   endfunction

   function automatic bit [NCH-1:0] done_at(int e);
      return a_done.exists(e) ? a_done[e] : '0;
   endfunction

   function automatic int sq_at(int e);
      return a_sq.exists(e) ? a_sq[e] : 0;
   endfunction

   // Mixer register contents after edge x (x > rst_edge for mixreg).
   function automatic int sumreg(int x);
      return (x <= rst_edge) ? 0 : sq_at(x - 1);
   endfunction

   function automatic int mixreg(int x);
      return (x - rst_edge) % NCH;
   endfunction

   // Channel ch plays n edges from e0 with period per and high-time thr.
   function automatic void play(int ch, int e0, int n, int per, int thr);
      bit [NCH-1:0] nb;
      for (int k = 0; k < n; k++) begin
         nb       = busy_at(e0 + k);
         nb[ch]   = 1'b1;
         a_busy[e0 + k] = nb;
         a_sq[e0 + k]   = sq_at(e0 + k) + (((k % per) < thr) ? 1 : 0);
      end
   endfunction

   function automatic void mark_done(int ch, int e);
      bit [NCH-1:0] nd;
      nd        = done_at(e);
      nd[ch]    = 1'b1;
      a_done[e] = nd;
   endfunction

   function automatic void push(int e, string tag);
      exp_t t;
      t.at   = e;
      t.tag  = tag;
      t.busy = busy_at(e);
      t.done = done_at(e);
      t.en   = (e <= rst_edge) ? 1'b0 : (busy_at(e - 1) != '0);
      t.pwm  = (e <= rst_edge + 1) ? 1'b0 : (mixreg(e - 1) < sumreg(e - 1));
      sb.push_back(t);
   endfunction

   function automatic void push_range(int e0, int e1, string tag);
      for (int e = e0; e <= e1; e++) push(e, tag);
   endfunction

   task automatic set_ch(input int ch, input int per, input int dur);
      period[ch*PW +: PW]   = PW'(per);
      duration[ch*DW +: DW] = DW'(dur);
   endtask

   task automatic step();
      exp_t t;
      @(posedge clock100);
      edge_n++;
      #1;
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
         t = sb.pop_front();
         checks++;
         assert (t.at == edge_n) else begin
            failures++;
            $error("FAIL %s.sched got_edge=%0d want_edge=%0d", t.tag, edge_n, t.at);
         end
         checks++;
         assert (busy === t.busy) else begin
            failures++;
            $error("FAIL %s.busy edge=%0d got=%b want=%b", t.tag, edge_n, busy, t.busy);
         end
         checks++;
         assert (done === t.done) else begin
            failures++;
            $error("FAIL %s.done edge=%0d got=%b want=%b", t.tag, edge_n, done, t.done);
         end
         checks++;
         assert (audEn === t.en) else begin
            failures++;
            $error("FAIL %s.audEn edge=%0d got=%b want=%b", t.tag, edge_n, audEn, t.en);
         end
         checks++;
         assert (audPWM === t.pwm) else begin
            failures++;
            $error("FAIL %s.audPWM edge=%0d got=%b want=%b", t.tag, edge_n, audPWM, t.pwm);
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      // Reset: outputs cleared, then a few idle cycles.
      reset = 1'b1;
      start = '1;
      set_ch(0, 4, 0);
      step();
      step();
      rst_edge = edge_n + 1;
      push(edge_n + 1, "reset");
      step();
      reset = 1'b0;
      start = '0;
      push_range(edge_n + 1, edge_n + 3, "idle");
      run(3);

      // Timed note: period 4, 3 ms -> 30 busy cycles, done on the 31st edge.
      set_ch(0, 4, 3);
      s = edge_n + 1;
      play(0, s, 30, 4, 2);
      mark_done(0, s + 30);
      push_range(s, s + 34, "timed");
      start[0] = 1'b1;
      step();
      start = '0;
      run(34);

      // Period below 2 is refused.
      set_ch(1, 1, 5);
      s = edge_n + 1;
      push_range(s, s + 5, "badper");
      start[1] = 1'b1;
      step();
      start = '0;
      run(5);

      // Untimed note stopped after 500 cycles, no done.
      set_ch(0, 6, 0);
      s = edge_n + 1;
      play(0, s, 500, 6, 3);
      push_range(s, s + 504, "untimed");
      start[0] = 1'b1;
      step();
      start = '0;
      run(499);
      stop[0] = 1'b1;
      step();
      stop = '0;
      run(4);

      // ch2 untimed, ch3 timed then restarted, invalid restart ignored,
      // then start+stop together on ch2.
      set_ch(2, 8, 0);
      set_ch(3, 4, 2);
      s = edge_n + 1;
      play(2, s, 12, 8, 4);
      play(3, s, 7, 4, 2);
      play(3, s + 7, 10, 6, 3);
      mark_done(3, s + 17);
      push_range(s, s + 22, "multi");
      start[2] = 1'b1;
      start[3] = 1'b1;
      step();
      start = '0;
      run(6);
      set_ch(3, 6, 1);
      start[3] = 1'b1;
      step();
      start = '0;
      run(2);
      set_ch(3, 1, 1);
      start[3] = 1'b1;
      step();
      start = '0;
      run(1);
      start[2] = 1'b1;
      stop[2]  = 1'b1;
      step();
      start = '0;
      stop  = '0;
      run(10);

      // All channels period 2 together, then reset mid-note (ch0 timed).
      for (int c = 0; c < NCH; c++) set_ch(c, 2, 0);
      set_ch(0, 2, 1);
      s = edge_n + 1;
      for (int c = 0; c < NCH; c++) play(c, s, 9, 2, 1);
      push_range(s, s + 8, "allch");
      start = '1;
      step();
      start = '0;
      run(8);
      reset    = 1'b1;
      rst_edge = edge_n + 1;
      push_range(rst_edge, rst_edge + 5, "midrst");
      step();
      reset = 1'b0;
      run(5);

`ifdef TONE_MIXER_DUTY_EN
      // duty 64 of 256 on period 8 -> high 2 of 8; duty 0 -> never high.
      duty[0 +: 8] = 8'd64;
      duty[8 +: 8] = 8'd0;
      set_ch(0, 8, 0);
      set_ch(1, 8, 0);
      s = edge_n + 1;
      play(0, s, 20, 8, 2);
      play(1, s, 20, 8, 0);
      push_range(s, s + 23, "duty");
      start[0] = 1'b1;
      start[1] = 1'b1;
      step();
      start = '0;
      run(19);
      stop[0] = 1'b1;
      stop[1] = 1'b1;
      step();
      stop = '0;
      run(3);
`endif

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL drain pending=%0d want=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
